// File: rtl/serial_add_sub_ctrl_if.sv
// Request/response bundle between a requesting datapath and the bit-serial
// add/sub controller. The requester drives operands; the controller reports status and results.
interface serial_add_sub_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, mode, a, b,
      input  busy, done, result, carry_out, overflow
   );

   modport slave (
      input  start, mode, a, b,
      output busy, done, result, carry_out, overflow
   );
endinterface

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial adder/subtractor: one shared full_adder cell is stepped LSB-first
// over WIDTH cycles. Subtraction is a + ~b + 1, with the +1 coming from the carry preload.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_add_sub_ctrl_if.slave bus
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0] sh_a_reg;
   logic [WIDTH-1:0] sh_b_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] result_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             cff_reg;
   logic             carry_out_reg;
   logic             overflow_reg;

   logic [WIDTH-1:0] b_load;
   logic [WIDTH-1:0] acc_next;
   logic             fa_sum;
   logic             fa_carry;
   logic             last_step;

   // Operand B is inverted on load for subtraction.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_b_load
         assign b_load[gi] = bus.b[gi] ^ bus.mode;
      end
   endgenerate

   full_adder u_full_adder (
      .a    (sh_a_reg[0]),
      .b    (sh_b_reg[0]),
      .cin  (cff_reg),
      .sum  (fa_sum),
      .cout (fa_carry)
   );

   assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));
   assign acc_next  = {fa_sum, acc_reg[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (last_step) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a_reg      <= '0;
         sh_b_reg      <= '0;
         acc_reg       <= '0;
         result_reg    <= '0;
         cnt_reg       <= '0;
         cff_reg       <= 1'b0;
         carry_out_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  sh_a_reg <= bus.a;
                  sh_b_reg <= b_load;
                  cff_reg  <= bus.mode;
                  cnt_reg  <= '0;
               end
            end
            RUN: begin
               sh_a_reg <= sh_a_reg >> 1;
               sh_b_reg <= sh_b_reg >> 1;
               acc_reg  <= acc_next;
               cff_reg  <= fa_carry;
               cnt_reg  <= cnt_reg + 1'b1;
               // cff_reg still holds the carry into the MSB on this step.
               if (last_step) begin
                  result_reg    <= acc_next;
                  carry_out_reg <= fa_carry;
                  overflow_reg  <= cff_reg ^ fa_carry;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state_reg != IDLE);
   assign bus.done      = (state_reg == DONE);
   assign bus.result    = result_reg;
   assign bus.carry_out = carry_out_reg;
   assign bus.overflow  = overflow_reg;
endmodule
